// File: rtl/matrix_stream_reader.sv
// Streams an M x N flat matrix bus one element per valid/ready transfer.
// Define MATRIX_STREAM_TRANSPOSE_EN for column-major (A-transpose) order.
`timescale 1ns/1ps

module matrix_stream_reader #(
  parameter int nBits = 32,
  parameter int M     = 32,
  parameter int N     = 16,
  localparam int RW   = (M > 1) ? $clog2(M) : 1,
  localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [M*N*nBits-1:0]   A,
  input  logic                   start,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [nBits-1:0]       m_data,
  output logic [RW-1:0]          m_row,
  output logic [CW-1:0]          m_col,
  output logic                   m_last_row,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int TOTAL_W = M * N * nBits;
  localparam int AW      = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;

  localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(N - 1);

  logic [1:0]       state, nxt_state;
  logic [RW-1:0]    row, nxt_row;
  logic [CW-1:0]    col, nxt_col;
  logic             at_last;
  logic             streaming_d;
  logic             last_row_d;
  logic             last_d;
  logic [AW-1:0]    elem_off;

  assign at_last = (row == ROW_MAX) && (col == COL_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_STREAM;
          nxt_row   = '0;
          nxt_col   = '0;
        end
      end
      S_STREAM: begin
        if (m_ready) begin
          if (at_last) begin
            nxt_state = S_DONE;
            nxt_row   = '0;
            nxt_col   = '0;
          end else begin
`ifdef MATRIX_STREAM_TRANSPOSE_EN
            if (row == ROW_MAX) begin
              nxt_row = '0;
              nxt_col = col + CW'(1);
            end else begin
              nxt_row = row + RW'(1);
            end
`else
            if (col == COL_MAX) begin
              nxt_col = '0;
              nxt_row = row + RW'(1);
            end else begin
              nxt_col = col + CW'(1);
            end
`endif
          end
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Element (0,0) is the most significant word of A.
  assign elem_off = AW'((M * N - 1 - (int'(nxt_row) * N + int'(nxt_col))) * nBits);

  assign streaming_d = (nxt_state == S_STREAM);
`ifdef MATRIX_STREAM_TRANSPOSE_EN
  assign last_row_d  = (nxt_row == ROW_MAX);
`else
  assign last_row_d  = (nxt_col == COL_MAX);
`endif
  assign last_d      = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      m_data     <= '0;
      m_last_row <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      state      <= nxt_state;
      row        <= nxt_row;
      col        <= nxt_col;
      // Re-fetched every cycle for the index that will be current; A is not snapshotted.
      m_data     <= streaming_d ? A[elem_off +: nBits] : '0;
      m_last_row <= streaming_d && last_row_d;
      m_last     <= streaming_d && last_d;
    end
  end

  assign m_valid = (state == S_STREAM);
  assign busy    = (state == S_STREAM);
  assign done    = (state == S_DONE);
  assign m_row   = row;
  assign m_col   = col;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Scoreboard bench for matrix_stream_reader: 2x3x8, default 32x16x32 and 1x1x8 instances.
`timescale 1ns/1ps

module tb_matrix_stream_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last_row;
    logic        last;
  } exp_t;

`ifdef MATRIX_STREAM_TRANSPOSE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2x3x8
  logic [47:0] a_a;
  logic start_a, ready_a, valid_a, lr_a, last_a, busy_a, done_a;
  logic [7:0] data_a;
  logic [0:0] row_a;
  logic [1:0] col_a;

  // Instance B: default 32x16x32
  logic [16383:0] a_b;
  logic start_b, ready_b, valid_b, lr_b, last_b, busy_b, done_b;
  logic [31:0] data_b;
  logic [4:0] row_b;
  logic [3:0] col_b;

  // Instance C: 1x1x8
  logic [7:0] a_c;
  logic start_c, ready_c, valid_c, lr_c, last_c, busy_c, done_c;
  logic [7:0] data_c;
  logic [0:0] row_c;
  logic [0:0] col_c;

  matrix_stream_reader #(.nBits(8), .M(2), .N(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .A(a_a), .start(start_a), .m_ready(ready_a),
    .m_valid(valid_a), .m_data(data_a), .m_row(row_a), .m_col(col_a),
    .m_last_row(lr_a), .m_last(last_a), .busy(busy_a), .done(done_a));

  matrix_stream_reader dut_b (
    .clk(clk), .rst_n(rst_n), .A(a_b), .start(start_b), .m_ready(ready_b),
    .m_valid(valid_b), .m_data(data_b), .m_row(row_b), .m_col(col_b),
    .m_last_row(lr_b), .m_last(last_b), .busy(busy_b), .done(done_b));

  matrix_stream_reader #(.nBits(8), .M(1), .N(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .A(a_c), .start(start_c), .m_ready(ready_c),
    .m_valid(valid_c), .m_data(data_c), .m_row(row_c), .m_col(col_c),
    .m_last_row(lr_c), .m_last(last_c), .busy(busy_c), .done(done_c));

  int n_pass = 0;
  int n_total = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t prev_pack[3];
  bit   prev_stall[3];
  bit   exp_done[3];
  int   xfer_cnt[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] val_b(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {kk ^ 16'hA5C3, kk};
  endfunction

  // Expected stream for one pass, in delivery order.
  task automatic push_pass(input int id, input int mm, input int nn);
    exp_t e;
    int r, c, k;
    for (int j = 0; j < mm * nn; j++) begin
      if (TR) begin r = j % mm; c = j / mm; end
      else    begin r = j / nn; c = j % nn; end
      k = r * nn + c;
      case (id)
        0:       e.data = 32'(k + 1);
        1:       e.data = val_b(k);
        default: e.data = 32'h0000_00A5;
      endcase
      e.row      = 8'(r);
      e.col      = 8'(c);
      e.last_row = TR ? (r == mm - 1) : (c == nn - 1);
      e.last     = (r == mm - 1) && (c == nn - 1);
      case (id)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  task automatic mon_step(input int id, input logic v, input logic r, input exp_t act,
                          input logic d, input logic b);
    exp_t e;
    int sz;
    if (!rst_n) begin
      prev_stall[id] = 1'b0;
      exp_done[id]   = 1'b0;
      return;
    end
    if (prev_stall[id])
      check($sformatf("stall_hold_%0d", id), {v, act}, {1'b1, prev_pack[id]});
    if (d || exp_done[id])
      check($sformatf("done_pulse_%0d", id), {d, b}, {exp_done[id], 1'b0});
    exp_done[id] = 1'b0;
    if (v && r) begin
      case (id)
        0:       sz = q_a.size();
        1:       sz = q_b.size();
        default: sz = q_c.size();
      endcase
      check($sformatf("sb_nonempty_%0d", id), sz != 0, 1);
      if (sz != 0) begin
        case (id)
          0:       e = q_a.pop_front();
          1:       e = q_b.pop_front();
          default: e = q_c.pop_front();
        endcase
        check($sformatf("xfer_%0d_%0d", id, xfer_cnt[id]), act, e);
      end
      if (act.last) exp_done[id] = 1'b1;
      xfer_cnt[id]++;
    end
    prev_stall[id] = v && !r;
    prev_pack[id]  = act;
  endtask

  always @(negedge clk)
    mon_step(0, valid_a, ready_a, exp_t'{32'(data_a), 8'(row_a), 8'(col_a), lr_a, last_a}, done_a, busy_a);
  always @(negedge clk)
    mon_step(1, valid_b, ready_b, exp_t'{data_b, 8'(row_b), 8'(col_b), lr_b, last_b}, done_b, busy_b);
  always @(negedge clk)
    mon_step(2, valid_c, ready_c, exp_t'{32'(data_c), 8'(row_c), 8'(col_c), lr_c, last_c}, done_c, busy_c);

  task automatic pulse_start(input int id);
    @(posedge clk); #1;
    case (id) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input int id, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      case (id) 0: seen = done_a; 1: seen = done_b; default: seen = done_c; endcase
    end
    check($sformatf("done_seen_%0d", id), seen, 1);
  endtask

  task automatic check_a_zero(input string name);
    check(name, {valid_a, data_a, row_a, col_a, lr_a, last_a, busy_a, done_a}, '0);
  endtask

  initial begin
    logic [3:0] pat;
    bit seen;
    pat = 4'b1001;
    rst_n = 1'b0;
    start_a = 0; start_b = 0; start_c = 0;
    ready_a = 0; ready_b = 0; ready_c = 0;
    a_a = 48'h010203040506;
    a_c = 8'hA5;
    for (int k = 0; k < 512; k++) a_b[14'((511 - k) * 32) +: 32] = val_b(k);
    for (int i = 0; i < 3; i++) xfer_cnt[i] = 0;

    #12;
    check_a_zero("reset_a");
    check("reset_b", {valid_b, data_b, row_b, col_b, lr_b, last_b, busy_b, done_b}, '0);
    check("reset_c", {valid_c, data_c, row_c, col_c, lr_c, last_c, busy_c, done_c}, '0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic 2x3 pass with ready held high
    ready_a = 1'b1;
    push_pass(0, 2, 3);
    pulse_start(0);
    check("start_resp_a", {valid_a, busy_a, data_a, row_a, col_a}, {1'b1, 1'b1, 8'h01, 1'b0, 2'd0});
    wait_done(0, 20);
    @(negedge clk);
    check("idle_after_done_a", {valid_a, busy_a, done_a}, 3'b000);
    check("sb_empty_a1", q_a.size(), 0);

    // Second start while streaming element 2 must be ignored
    push_pass(0, 2, 3);
    pulse_start(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(0, 20);
    repeat (3) @(negedge clk);
    check("sb_empty_a2", q_a.size(), 0);
    check("idle_after_ignore_a", {valid_a, busy_a, done_a}, 3'b000);

    // Reset after the third transfer, then a fresh full pass
    xfer_cnt[0] = 0;
    push_pass(0, 2, 3);
    pulse_start(0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    check("xfers_before_reset_a", xfer_cnt[0], 3);
    rst_n = 1'b0;
    #1;
    check_a_zero("midstream_reset_a");
    q_a.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_a_zero("after_reset_idle_a");
    push_pass(0, 2, 3);
    pulse_start(0);
    check("restart_first_a", {valid_a, data_a}, {1'b1, 8'h01});
    wait_done(0, 20);
    repeat (2) @(negedge clk);
    check("sb_empty_a3", q_a.size(), 0);

    // Default geometry with 1,0,0,1 ready pattern
    xfer_cnt[1] = 0;
    push_pass(1, 32, 16);
    ready_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      ready_b = pat[cyc % 4];
      if (done_b) seen = 1'b1;
    end
    check("done_seen_b", seen, 1);
    @(negedge clk);
    check("xfers_b", xfer_cnt[1], 512);
    check("sb_empty_b", q_b.size(), 0);
    ready_b = 1'b0;

    // 1x1 matrix
    ready_c = 1'b1;
    push_pass(2, 1, 1);
    pulse_start(2);
    check("start_resp_c", {valid_c, data_c, lr_c, last_c}, {1'b1, 8'hA5, 1'b1, 1'b1});
    wait_done(2, 10);
    @(negedge clk);
    check("sb_empty_c", q_c.size(), 0);
    check("idle_after_done_c", {valid_c, busy_c, done_c}, 3'b000);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
